// File: rtl/beta_shift_issue_ctrl.sv
// Purpose: issue one shift op to the multi-cycle shift unit, sequence it for shamt cycles, hand result to writeback.
// Latency: wb_valid_o rises one cycle after the accept edge for shamt==0 or an illegal mode, otherwise shamt+1 cycles later.
// Backpressure: one op in flight; req_ready_o stays low until the writeback handshake completes.
module beta_shift_issue_ctrl #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] req_a_i,
  input  logic [4:0]      req_shamt_i,
  input  logic [1:0]      req_mode_i,
  input  logic [RD_W-1:0] req_rd_i,
  output logic            shu_en_o,
  output logic [1:0]      shu_mode_o,
  output logic [XLEN-1:0] shu_operand_a_o,
  output logic [4:0]      shu_operand_b_o,
  input  logic            shu_busy_i,
  input  logic [XLEN-1:0] shu_result_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [RD_W-1:0] wb_rd_o,
  output logic            illegal_o,
  output logic            proto_err_o
);

  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC    = 2'd1,
    S_CAPTURE = 2'd2,
    S_WB      = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] op_a_q;
  logic [4:0]      op_shamt_q;
  logic [1:0]      op_mode_q;
  logic [XLEN-1:0] wb_data_q;
  logic [RD_W-1:0] wb_rd_q;
  logic            illegal_q;
  logic            proto_err_q;
  logic            accept;
  logic            bypass;

  // Ready is held low while in reset so the execute stage never sees a phantom accept.
  assign req_ready_o = rstn_i & (state_q == S_IDLE) & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;
  assign bypass      = (req_mode_i == MODE_ILLEGAL) || (req_shamt_i == 5'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (bypass) begin
              state_d = S_WB;
            end else begin
              state_d = S_EXEC;
              cnt_d   = req_shamt_i - 5'd1;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == 5'd0) state_d = S_CAPTURE;
          else               cnt_d   = cnt_q - 5'd1;
        end
        S_CAPTURE: state_d = S_WB;
        S_WB: begin
          if (wb_ready_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand registers only change on accept, so they are stable for the whole EXEC phase.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      op_a_q      <= '0;
      op_shamt_q  <= '0;
      op_mode_q   <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      illegal_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      illegal_q   <= accept && (req_mode_i == MODE_ILLEGAL);
      proto_err_q <= proto_err_q | ((state_q == S_IDLE) & shu_busy_i);
      if (accept) begin
        op_a_q     <= req_a_i;
        op_shamt_q <= req_shamt_i;
        op_mode_q  <= req_mode_i;
        wb_rd_q    <= req_rd_i;
        if (bypass) wb_data_q <= req_a_i;
      end
      if ((state_q == S_CAPTURE) && !flush_i) wb_data_q <= shu_result_i;
    end
  end

  assign shu_en_o        = (state_q == S_EXEC);
  assign shu_mode_o      = op_mode_q;
  assign shu_operand_a_o = op_a_q;
  assign shu_operand_b_o = op_shamt_q;
  assign wb_valid_o      = (state_q == S_WB);
  assign wb_data_o       = wb_data_q;
  assign wb_rd_o         = wb_rd_q;
  assign illegal_o       = illegal_q;
  assign proto_err_o     = proto_err_q;

endmodule

// File: tb/tb_beta_shift_issue_ctrl.sv
// Bench for beta_shift_issue_ctrl: a bit-serial shift unit model, a vector table, random ops
// checked against whole-word shift arithmetic, and hand sequences for backpressure/flush/reset.
module tb_beta_shift_issue_ctrl;

  localparam logic [1:0] SL = 2'd0, SR = 2'd1, SA = 2'd2, SX = 2'd3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [4:0]  req_shamt = '0;
  logic [1:0]  req_mode = '0;
  logic [4:0]  req_rd = '0;
  logic        shu_en;
  logic [1:0]  shu_mode;
  logic [31:0] shu_opa;
  logic [4:0]  shu_opb;
  logic        shu_busy;
  logic [31:0] shu_result;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        illegal;
  logic        proto_err;
  logic        busy_force = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  beta_shift_issue_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clk_i(clk), .rstn_i(rstn), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_shamt_i(req_shamt), .req_mode_i(req_mode), .req_rd_i(req_rd),
    .shu_en_o(shu_en), .shu_mode_o(shu_mode), .shu_operand_a_o(shu_opa), .shu_operand_b_o(shu_opb),
    .shu_busy_i(shu_busy), .shu_result_i(shu_result),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_rd_o(wb_rd),
    .illegal_o(illegal), .proto_err_o(proto_err)
  );

  // Shift unit model: loads operand A on the first enabled cycle, shifts one bit per enabled cycle.
  logic [31:0] unit_r;
  logic        unit_prev;
  function automatic logic [31:0] step1(input logic [31:0] v, input logic [1:0] m);
    case (m)
      SL:      return {v[30:0], 1'b0};
      SR:      return {1'b0, v[31:1]};
      SA:      return {v[31], v[31:1]};
      default: return v;
    endcase
  endfunction
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      unit_r    <= '0;
      unit_prev <= 1'b0;
    end else begin
      unit_prev <= shu_en;
      if (shu_en) unit_r <= step1(unit_prev ? unit_r : shu_opa, shu_mode);
    end
  end
  assign shu_result = unit_r;
  assign shu_busy   = shu_en | busy_force;

  // Reference: whole-word shift straight from the op definition.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] m);
    case (m)
      SL:      return a << sh;
      SR:      return a >> sh;
      SA:      return 32'($signed(a) >>> sh);
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] md,
                        input logic [4:0] rd, input int delay, input logic [31:0] exp);
    int t, cyc, lat, en_cnt, ill_cnt, opnd_bad, hold_bad, exp_lat, exp_en;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_shamt = sh; req_mode = md; req_rd = rd;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cyc = 0; lat = 0; en_cnt = 0; ill_cnt = 0; opnd_bad = 0;
    while (lat == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      req_valid = 1'b0;
      if (shu_en) begin
        en_cnt++;
        if (shu_opa !== a || shu_opb !== sh || shu_mode !== md) opnd_bad++;
      end
      if (illegal) ill_cnt++;
      if (wb_valid) lat = cyc;
    end
    exp_lat = (sh == 5'd0 || md == SX) ? 1 : int'(sh) + 2;
    exp_en  = (md == SX) ? 0 : int'(sh);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("en_cycles", 32'(en_cnt), 32'(exp_en));
    chk("operands", 32'(opnd_bad), 32'd0);
    chk("wb_data", wb_data, exp);
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    hold_bad = 0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (!wb_valid || wb_data !== exp || wb_rd !== rd || req_ready || shu_en) hold_bad++;
      if (illegal) ill_cnt++;
    end
    chk("illegal_pulse", 32'(ill_cnt), (md == SX) ? 32'd1 : 32'd0);
    if (delay > 0) chk("wb_hold", 32'(hold_bad), 32'd0);
    wb_ready = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0;
    chk("idle_after_wb", {30'd0, wb_valid, req_ready}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [4:0]  sh;
    logic [1:0]  md;
    logic [4:0]  rd;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int pulses, w, gap, mingap, maxw, wbs, bad;
    logic seen;
    logic [31:0] ra;
    logic [4:0]  rsh, rrd;
    logic [1:0]  rmd;

    vecs[0] = '{32'h0000_0001, 5'd4,  SL, 5'd3,  0,  32'h0000_0010};
    vecs[1] = '{32'h8000_0000, 5'd31, SA, 5'd4,  1,  32'hFFFF_FFFF};
    vecs[2] = '{32'h8000_0000, 5'd31, SR, 5'd5,  0,  32'h0000_0001};
    vecs[3] = '{32'hDEAD_BEEF, 5'd0,  SL, 5'd6,  0,  32'hDEAD_BEEF};
    vecs[4] = '{32'h1234_5678, 5'd8,  SL, 5'd7,  10, 32'h3456_7800};
    vecs[5] = '{32'hF000_0000, 5'd4,  SA, 5'd8,  2,  32'hFF00_0000};
    vecs[6] = '{32'hCAFE_BABE, 5'd5,  SX, 5'd9,  0,  32'hCAFE_BABE};
    vecs[7] = '{32'h0000_FFFF, 5'd1,  SR, 5'd31, 0,  32'h0000_7FFF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_ctl", {27'd0, shu_en, wb_valid, illegal, proto_err, 1'b0}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_opa", shu_opa, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].sh, vecs[i].md, vecs[i].rd, vecs[i].delay, vecs[i].exp);

    for (int k = 0; k < 30; k++) begin
      ra  = $urandom;
      rsh = 5'($urandom_range(0, 31));
      rmd = 2'($urandom_range(0, 3));
      rrd = 5'($urandom_range(0, 31));
      run_op(ra, rsh, rmd, rrd, int'($urandom_range(0, 3)), ref_shift(ra, rsh, rmd));
    end

    // Back-to-back shamt=1 ops with writeback always ready
    @(negedge clk);
    wb_ready = 1'b1; req_valid = 1'b1; req_a = 32'h0000_0003; req_shamt = 5'd1; req_mode = SL; req_rd = 5'd2;
    pulses = 0; w = 0; gap = 0; mingap = 99; maxw = 0; wbs = 0; seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (shu_en) begin
        if (w == 0 && seen && gap < mingap) mingap = gap;
        w++; gap = 0;
      end else begin
        if (w > 0) begin pulses++; seen = 1'b1; if (w > maxw) maxw = w; end
        w = 0; gap++;
      end
      if (wb_valid && wb_data == 32'h0000_0006) wbs++;
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    wb_ready = 1'b0;
    chk("b2b_pulse_width", 32'(maxw), 32'd1);
    chk("b2b_gap_ge2", 32'(mingap >= 2), 32'd1);
    chk("b2b_pulses_ge3", 32'(pulses >= 3), 32'd1);
    chk("b2b_wb_ge3", 32'(wbs >= 3), 32'd1);

    // Flush in the second EXEC cycle of a shamt=8 op
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h0000_00FF; req_shamt = 5'd8; req_mode = SL; req_rd = 5'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_en", 32'(shu_en), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_idle", {29'd0, shu_en, wb_valid, req_ready}, 32'd1);
    bad = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); if (wb_valid || shu_en) bad++; end
    chk("flush_no_wb", 32'(bad), 32'd0);

    // Flush coinciding with the writeback handshake
    req_valid = 1'b1; req_a = 32'h0000_0055; req_shamt = 5'd0; req_mode = SL; req_rd = 5'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("flush_wb_pre", 32'(wb_valid), 32'd1);
    wb_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    wb_ready = 1'b0; flush = 1'b0;
    #1;
    chk("flush_wb_idle", {30'd0, wb_valid, req_ready}, 32'd1);

    // Protocol error: busy while idle is sticky
    chk("proto_clear", 32'(proto_err), 32'd0);
    @(negedge clk);
    busy_force = 1'b1;
    @(negedge clk);
    busy_force = 1'b0;
    chk("proto_set", 32'(proto_err), 32'd1);
    run_op(32'h0000_0100, 5'd2, SR, 5'd10, 0, 32'h0000_0040);
    chk("proto_sticky", 32'(proto_err), 32'd1);

    // Mid-op reset
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h0000_0001; req_shamt = 5'd20; req_mode = SL; req_rd = 5'd12;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ctl", {27'd0, shu_en, wb_valid, illegal, proto_err, req_ready}, 32'd0);
    chk("mid_rst_data", wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    run_op(32'h8000_0000, 5'd3, SA, 5'd13, 0, 32'hF000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
